// File: rtl/ifetch_decode.sv
// rtl/ifetch_decode.sv - instruction fetch/decode front end; optional halt opcode under FETCH_HALT_EN
module ifetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_cs,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        br_valid,
  input  logic [7:0]  br_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  fetch_pc;
  logic [7:0]  pc_q;
  logic [31:0] instr;
  logic        halt_op;

`ifdef FETCH_HALT_EN
  assign halt_op = (instr[31:26] == 6'h3F);
  assign halted  = (state == S_HALT);
`else
  assign halt_op = 1'b0;
  assign halted  = 1'b0;
`endif

  // A redirect in REQ makes the current fetch pointless, so the chip select is
  // suppressed; this also keeps imem_cs from firing on two consecutive cycles.
  assign imem_cs   = rst_n && (state == S_REQ) && !br_valid;
  assign imem_addr = fetch_pc;
  assign dec_valid = (state == S_HOLD);

  assign pc     = pc_q;
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // Fetch FSM: REQ -> WAIT -> HOLD, redirects win over everything except HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      instr    <= '0;
    end else if (state != S_HALT && br_valid) begin
      fetch_pc <= br_target;
      state    <= S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          instr <= imem_data;
          pc_q  <= fetch_pc;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (dec_ready) begin
            if (halt_op) begin
              state <= S_HALT;
            end else begin
              fetch_pc <= fetch_pc + 8'd1;
              state    <= S_REQ;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_decode.sv
// tb/tb_ifetch_decode.sv - self-checking bench for ifetch_decode with a transaction-age reference model
module tb_ifetch_decode;

  localparam logic [7:0] RESET_PC = 8'h00;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_cs;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [7:0]  pc;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        halted;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];

  // Reference model state: age counts cycles since the current fetch began
  // (0 = address phase, 1 = data phase, >=2 = instruction presented).
  bit         m_known = 1'b0;
  int         m_age;
  logic [7:0] m_fetch;
  bit         m_halted;
  bit         m_fresh;
  bit         prev_cs = 1'b0;

  ifetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_cs(imem_cs), .imem_addr(imem_addr),
    .imem_data(imem_data), .br_valid(br_valid), .br_target(br_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .pc(pc), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: registers the word on a chip-select edge.
  always @(posedge clk) begin
    if (imem_cs) imem_data <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic        exp_cs;
    logic        exp_valid;
    logic [31:0] w;
    if (!m_known) return;
    exp_cs    = rst_n && !m_halted && (m_age == 0) && !br_valid;
    exp_valid = !m_halted && (m_age >= 2);
    chk("m_cs", {31'd0, imem_cs}, {31'd0, exp_cs});
    chk("m_valid", {31'd0, dec_valid}, {31'd0, exp_valid});
    chk("m_halted", {31'd0, halted}, {31'd0, m_halted});
    if (prev_cs) chk("m_cs_b2b", {31'd0, imem_cs}, 32'd0);
    if (exp_cs) chk("m_addr", {24'd0, imem_addr}, {24'd0, m_fetch});
    if (exp_valid) begin
      w = mem[m_fetch];
      chk("m_pc", {24'd0, pc}, {24'd0, m_fetch});
      chk("m_fields", {opcode, rs, rt, rd, funct, imm},
          {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]});
    end else if (m_fresh) begin
      chk("m_reset_pc", {24'd0, pc}, {24'd0, RESET_PC});
      chk("m_reset_fields", {opcode, rs, rt, rd, funct, imm}, 44'd0);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_known  = 1'b1;
      m_age    = 0;
      m_fetch  = RESET_PC;
      m_halted = 1'b0;
      m_fresh  = 1'b1;
    end else if (!m_known || m_halted) begin
      // nothing moves
    end else if (br_valid) begin
      m_fetch = br_target;
      m_age   = 0;
    end else if (m_age < 2) begin
      if (m_age == 1) m_fresh = 1'b0;
      m_age++;
    end else if (dec_ready) begin
      if (HALT_EN && mem[m_fetch][31:26] == 6'h3F) begin
        m_halted = 1'b1;
      end else begin
        m_fetch = m_fetch + 8'd1;
        m_age   = 0;
      end
    end
  endtask

  // Called at a negedge: drive this cycle's inputs and compare against the model.
  task automatic set_in(input logic r, input logic b, input logic [7:0] t, input logic d);
    rst_n = r; br_valid = b; br_target = t; dec_ready = d;
    #1;
    model_check();
  endtask

  // Advance through the active edge, update the model, land on the next negedge.
  task automatic adv();
    @(posedge clk);
    prev_cs = imem_cs;
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_target = 8'h00; dec_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h00] = 32'h012A4020;
    mem[8'h01] = 32'h00221820;
    mem[8'h40] = 32'h8C221234;
    mem[8'h41] = 32'h00000000;
    mem[8'hFF] = 32'h11111111;
    mem[8'h80] = 32'hFC000000;
    @(negedge clk);

    // Reset state
    set_in(0, 0, 8'h00, 1); adv();
    set_in(0, 0, 8'h00, 1);
    chk("rst_cs", {31'd0, imem_cs}, 32'd0);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_fields", {opcode, rs, rt, rd, funct, imm}, 44'd0);
    adv();

    // First fetch and decode of word 0
    set_in(1, 0, 8'h00, 1);
    chk("first_cs", {31'd0, imem_cs}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'h00);
    adv();
    set_in(1, 0, 8'h00, 0);
    chk("c1_valid", {31'd0, dec_valid}, 32'd0);
    adv();
    set_in(1, 0, 8'h00, 0);
    chk("c2_valid", {31'd0, dec_valid}, 32'd1);
    chk("c2_pc", {24'd0, pc}, 32'h00);
    chk("c2_rs", {27'd0, rs}, 32'd9);
    chk("c2_rt", {27'd0, rt}, 32'd10);
    chk("c2_rd", {27'd0, rd}, 32'd8);
    chk("c2_funct", {26'd0, funct}, 32'h20);
    adv();

    // Backpressure: outputs frozen while dec_ready is low
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 8'h00, 0);
      chk("hold_valid", {31'd0, dec_valid}, 32'd1);
      chk("hold_cs", {31'd0, imem_cs}, 32'd0);
      chk("hold_rs", {27'd0, rs}, 32'd9);
      chk("hold_fetch", {24'd0, imem_addr}, 32'h00);
      adv();
    end
    set_in(1, 0, 8'h00, 1); adv();
    set_in(1, 0, 8'h00, 0);
    chk("next_addr", {24'd0, imem_addr}, 32'h01);
    chk("next_cs", {31'd0, imem_cs}, 32'd1);
    adv();

    // Redirect during WAIT drops the returned word
    set_in(1, 1, 8'h40, 0); adv();
    set_in(1, 0, 8'h00, 0);
    chk("br_valid_drop", {31'd0, dec_valid}, 32'd0);
    chk("br_addr", {24'd0, imem_addr}, 32'h40);
    chk("br_cs", {31'd0, imem_cs}, 32'd1);
    adv();
    set_in(1, 0, 8'h00, 0); adv();
    set_in(1, 0, 8'h00, 1);
    chk("br_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("br_pc", {24'd0, pc}, 32'h40);
    chk("br_opcode", {26'd0, opcode}, 32'h23);
    chk("br_imm", {16'd0, imm}, 32'h1234);
    adv();

    // Redirect in REQ to 8'hFF, then wrap to 8'h00
    set_in(1, 1, 8'hFF, 0);
    chk("br_req_cs", {31'd0, imem_cs}, 32'd0);
    adv();
    set_in(1, 0, 8'h00, 1);
    chk("ff_addr", {24'd0, imem_addr}, 32'hFF);
    adv();
    set_in(1, 0, 8'h00, 1); adv();
    set_in(1, 0, 8'h00, 1);
    chk("ff_pc", {24'd0, pc}, 32'hFF);
    adv();
    set_in(1, 0, 8'h00, 1);
    chk("wrap_addr", {24'd0, imem_addr}, 32'h00);
    chk("wrap_cs", {31'd0, imem_cs}, 32'd1);
    adv();
    set_in(1, 0, 8'h00, 0); adv();
    set_in(1, 0, 8'h00, 0);
    chk("pre_rst_valid", {31'd0, dec_valid}, 32'd1);
    adv();

    // Reset during HOLD
    set_in(0, 0, 8'h00, 0);
    chk("rst_hold_cs", {31'd0, imem_cs}, 32'd0);
    adv();
    set_in(1, 0, 8'h00, 1);
    chk("rst_hold_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_hold_addr", {24'd0, imem_addr}, {24'd0, RESET_PC});
    chk("rst_hold_cs1", {31'd0, imem_cs}, 32'd1);
    adv();

`ifdef FETCH_HALT_EN
    // Halt opcode: accepted, then fetch stops and redirects are ignored
    set_in(1, 1, 8'h80, 1); adv();
    set_in(1, 0, 8'h00, 1); adv();
    set_in(1, 0, 8'h00, 1); adv();
    set_in(1, 0, 8'h00, 1);
    chk("halt_op_valid", {31'd0, dec_valid}, 32'd1);
    adv();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 8'h10, 1);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_cs", {31'd0, imem_cs}, 32'd0);
      chk("halt_valid", {31'd0, dec_valid}, 32'd0);
      adv();
    end
    set_in(0, 0, 8'h00, 0); adv();
`endif

    // Randomized traffic against the model
    set_in(0, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h05] = 32'hFC000000;
    adv();
    for (int i = 0; i < 4000; i++) begin
      set_in(($urandom_range(0, 79) != 0),
             ($urandom_range(0, 7) == 0),
             8'($urandom_range(0, 255)),
             ($urandom_range(0, 1) == 1));
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
